data_resp: RTL and testbench
============================

DATA_RESP -- requirements
Module: data_resp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of data BRAM read word.
REQ-002 SHALL have parameter BRAM_LATENCY, default 2, meaning cycles from rden to valid BRAM dout (legal 1..4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning response buffer entries (power of 2, >= BRAM_LATENCY).
REQ-004 SHALL have parameter REG_WIDTH, default 32, meaning debug register width.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_rden  input  1  read enable issued to data BRAM by the requester.
REQ-008 SHALL have port i_last  input  1  marks the final read of a kernel line; qualified by i_rden.
REQ-009 SHALL have port i_bram_dout  input  DATA_WIDTH  BRAM read data.
REQ-010 SHALL have port o_stall  output  1  back-pressure to the requester; no new i_rden accepted while high.
REQ-011 SHALL have port o_data  output  DATA_WIDTH  response data to the PE array.
REQ-012 SHALL have port o_valid  output  1  o_data/o_last valid.
REQ-013 SHALL have port o_last  output  1  beat corresponds to an i_last read.
REQ-014 SHALL have port i_ready  input  1  consumer accepts beat when o_valid & i_ready.
REQ-015 SHALL have port o_err_ovf  output  1  sticky protocol error: i_rden while o_stall.

Function
REQ-016 SHALL shift {i_rden, i_last} through a BRAM_LATENCY-deep valid pipeline aligned to i_bram_dout.
REQ-017 SHALL write {i_bram_dout, last} into FIFO in the cycle the pipeline output valid is high.
REQ-018 SHALL present FIFO head first-word-fall-through: entry written in cycle c visible on o_valid in c+1; min rden-to-o_valid latency BRAM_LATENCY+1.
REQ-019 SHALL pop head on o_valid & i_ready; o_data/o_last stable while o_valid & ~i_ready.
REQ-020 SHALL keep inflight_cnt = reads in pipeline, fifo_cnt = stored entries; both exact every cycle.
REQ-021 SHALL drive o_stall combinationally = (fifo_cnt + inflight_cnt) >= FIFO_DEPTH, computed from registered counts only (no path from i_rden).
REQ-022 SHALL guarantee FIFO never overflows when requester obeys o_stall, including simultaneous push and pop.
REQ-023 SHALL on i_rden & o_stall: still track the read, drop the excess write if FIFO full, set o_err_ovf until reset.
REQ-024 SHALL never pop when empty; o_valid low when fifo_cnt == 0.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH; counter widths $clog2(FIFO_DEPTH)+1.
REQ-026 SHALL preserve order: beats leave in i_rden order, o_last on exactly the beat of the i_last read.

Reset
REQ-027 SHALL on rst clear valid pipeline, pointers, counts; o_valid=0, o_last=0, o_stall=0, o_err_ovf=0, o_data=0.
REQ-028 SHALL discard in-flight reads when rst asserts mid-operation; no beat emitted for them after rst deasserts.

Configuration
REQ-029 SHALL, with DATA_RESP_DBG_EN defined, add outputs dbg_dataresp_beat_cnt and dbg_dataresp_stall_cnt (REG_WIDTH, count accepted beats and o_stall cycles, wrap, cleared by rst).
REQ-030 SHALL, without DATA_RESP_DBG_EN, omit those ports and counters; functional behaviour identical.

Structure
REQ-031 SHALL place default DATA_WIDTH, BRAM_LATENCY, FIFO_DEPTH constants in shared package dnn_accel_pkg.
REQ-032 SHALL implement buffer as sub-module data_resp_fifo (sync FWFT FIFO, count output); pipeline and stall logic in data_resp.

Verification
REQ-033 SHALL verify: rst, single i_rden with i_bram_dout=0xA5A5_0001, LAT=2, i_ready=1 -> o_valid one cycle, 3 cycles after rden, o_data=0xA5A5_0001.
REQ-034 SHALL verify: continuous i_rden honoring o_stall, i_ready=0 -> exactly 4 beats buffered, o_stall=1 from cycle inflight+fifo=4, no loss.
REQ-035 SHALL verify: 16 reads data 0..15, i_last on 15th, random i_ready -> order 0..15, o_last only on data 15.
REQ-036 SHALL verify: FIFO full, simultaneous pop and push -> fifo_cnt stays 4, no overflow, o_err_ovf=0.
REQ-037 SHALL verify: i_rden forced while o_stall=1 -> o_err_ovf=1 next cycle, held until rst.
REQ-038 SHALL verify: rst mid-burst with 2 reads in flight -> o_valid=0 and no stale beats afterwards; DBG counters (if enabled) read 0.

Source files
------------

// File: rtl/dnn_accel_pkg.sv
// -----------------------------------------------------------------------------
// dnn_accel_pkg
// Shared constants and types for the DNN accelerator data path.
//   DEF_DATA_WIDTH   : default data BRAM read word width
//   DEF_BRAM_LATENCY : default cycles from rden to valid BRAM dout
//   DEF_FIFO_DEPTH   : default response buffer depth
//   DEF_REG_WIDTH    : default debug register width
//   rd_tag_t         : per-read tag carried alongside the BRAM latency
// -----------------------------------------------------------------------------
package dnn_accel_pkg;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_BRAM_LATENCY = 2;
   localparam int DEF_FIFO_DEPTH   = 4;
   localparam int DEF_REG_WIDTH    = 32;

   // Tag travelling with each read until its BRAM data is available.
   typedef struct packed {
      logic vld;
      logic last;
   } rd_tag_t;

endpackage : dnn_accel_pkg

// File: rtl/data_resp_fifo.sv
// -----------------------------------------------------------------------------
// data_resp_fifo
// Synchronous first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   wr_en_i     : push request (ignored when full unless a pop happens too)
//   wr_data_i   : push data
//   rd_en_i     : pop request (ignored when empty)
//   rd_data_o   : head entry, zero while empty
//   valid_o     : head entry valid (FIFO not empty)
//   count_o     : number of stored entries
// -----------------------------------------------------------------------------
module data_resp_fifo #(
   parameter  int WIDTH = 33,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             valid_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             empty, full, do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = rd_en_i & ~empty;
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = wr_en_i & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the head is masked to zero while empty instead.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // Head is read asynchronously so a write in cycle c is visible in c+1.
   assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
   assign valid_o   = ~empty;
   assign count_o   = count_q;

endmodule : data_resp_fifo

// File: rtl/data_resp.sv
// -----------------------------------------------------------------------------
// data_resp
// Response path for data BRAM reads: tracks reads through the BRAM latency,
// buffers returned words in a FWFT FIFO and throttles the requester so the
// buffer can never overflow.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_rden       : read enable issued to the data BRAM
//   i_last       : final read of a kernel line (qualified by i_rden)
//   i_bram_dout  : BRAM read data, valid BRAM_LATENCY cycles after i_rden
//   o_stall      : back-pressure, no new read may be issued while high
//   o_data       : response data
//   o_valid      : o_data / o_last valid
//   o_last       : beat belongs to an i_last read
//   i_ready      : consumer accepts the beat when o_valid & i_ready
//   o_err_ovf    : sticky flag, a read was issued while o_stall was high
// Optional (macro DATA_RESP_DBG_EN):
//   dbg_dataresp_beat_cnt  : accepted beats, wrapping
//   dbg_dataresp_stall_cnt : cycles with o_stall high, wrapping
// -----------------------------------------------------------------------------
module data_resp
   import dnn_accel_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int BRAM_LATENCY = DEF_BRAM_LATENCY,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int REG_WIDTH    = DEF_REG_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_rden,
   input  logic                  i_last,
   input  logic [DATA_WIDTH-1:0] i_bram_dout,
   output logic                  o_stall,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_last,
   input  logic                  i_ready,
   output logic                  o_err_ovf
`ifdef DATA_RESP_DBG_EN
   ,
   output logic [REG_WIDTH-1:0]  dbg_dataresp_beat_cnt,
   output logic [REG_WIDTH-1:0]  dbg_dataresp_stall_cnt
`endif
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int LAT = BRAM_LATENCY;

   rd_tag_t             pipe_q [LAT];
   logic [CW-1:0]       inflight_q, inflight_d;
   logic [CW-1:0]       fifo_cnt;
   logic [CW:0]         occupancy;
   logic                err_ovf_q, err_ovf_d;
   logic                pop;
   logic [DATA_WIDTH:0] fifo_head;

   // Tag pipeline: stage LAT-1 lines up with the BRAM word of the same read.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
      end else begin
         pipe_q[0].vld  <= i_rden;
         pipe_q[0].last <= i_rden & i_last;
         for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
      end
   end

   always_comb begin
      inflight_d = inflight_q + CW'(i_rden) - CW'(pipe_q[LAT-1].vld);
      err_ovf_d  = err_ovf_q | (i_rden & o_stall);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= '0;
         err_ovf_q  <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   // Reserve a slot for every read still inside the BRAM; only registered
   // counts feed this, so o_stall has no combinational path from i_rden.
   assign occupancy = {1'b0, fifo_cnt} + {1'b0, inflight_q};
   assign o_stall   = (occupancy >= (CW+1)'(FIFO_DEPTH));
   assign pop       = o_valid & i_ready;

   data_resp_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (pipe_q[LAT-1].vld),
      .wr_data_i ({pipe_q[LAT-1].last, i_bram_dout}),
      .rd_en_i   (pop),
      .rd_data_o (fifo_head),
      .valid_o   (o_valid),
      .count_o   (fifo_cnt)
   );

   assign o_data    = fifo_head[DATA_WIDTH-1:0];
   assign o_last    = fifo_head[DATA_WIDTH];
   assign o_err_ovf = err_ovf_q;

`ifdef DATA_RESP_DBG_EN
   logic [REG_WIDTH-1:0] beat_cnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (pop)     beat_cnt_q  <= beat_cnt_q + REG_WIDTH'(1);
         if (o_stall) stall_cnt_q <= stall_cnt_q + REG_WIDTH'(1);
      end
   end

   assign dbg_dataresp_beat_cnt  = beat_cnt_q;
   assign dbg_dataresp_stall_cnt = stall_cnt_q;
`endif

endmodule : data_resp

// File: tb/tb_data_resp.sv
// -----------------------------------------------------------------------------
// tb_data_resp
// Self-checking bench for data_resp with default parameters. A BRAM model
// delays the requested word by BRAM_LATENCY cycles; every issued read pushes
// its expected beat into a scoreboard queue that is popped on each handshake.
// -----------------------------------------------------------------------------
module tb_data_resp;
   import dnn_accel_pkg::*;

   localparam int DW  = DEF_DATA_WIDTH;
   localparam int LAT = DEF_BRAM_LATENCY;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_rden = 1'b0;
   logic          i_last = 1'b0;
   logic          i_ready = 1'b0;
   logic [DW-1:0] i_bram_dout;
   logic          o_stall, o_valid, o_last, o_err_ovf;
   logic [DW-1:0] o_data;
   logic [DW-1:0] rd_word = '0;
   logic [DW-1:0] bram_pipe [LAT];
`ifdef DATA_RESP_DBG_EN
   logic [DEF_REG_WIDTH-1:0] dbg_beat, dbg_stall;
`endif

   logic [DW:0] sb_q [$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   data_resp dut (
      .clk         (clk),
      .rst         (rst),
      .i_rden      (i_rden),
      .i_last      (i_last),
      .i_bram_dout (i_bram_dout),
      .o_stall     (o_stall),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_last      (o_last),
      .i_ready     (i_ready),
      .o_err_ovf   (o_err_ovf)
`ifdef DATA_RESP_DBG_EN
      ,
      .dbg_dataresp_beat_cnt  (dbg_beat),
      .dbg_dataresp_stall_cnt (dbg_stall)
`endif
   );

   // BRAM model: word presented with a read appears LAT cycles later.
   always @(posedge clk) begin
      bram_pipe[0] <= rd_word;
      for (int k = 1; k < LAT; k++) bram_pipe[k] <= bram_pipe[k-1];
   end
   assign i_bram_dout = bram_pipe[LAT-1];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Scoreboard: every accepted beat must match the oldest outstanding read.
   always @(negedge clk) begin
      if (!rst && o_valid && i_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_extra_beat", 64'(sb_q.size()), 64'd1);
         end else begin
            logic [DW:0] exp_beat;
            exp_beat = sb_q.pop_front();
            chk("beat_data", 64'(o_data), 64'(exp_beat[DW-1:0]));
            chk("beat_last", 64'(o_last), 64'(exp_beat[DW]));
            $display("beat data=0x%08h last=%0b", o_data, o_last);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [DW-1:0] d, input logic last);
      i_rden  = 1'b1;
      i_last  = last;
      rd_word = d;
      sb_q.push_back({last, d});
   endtask

   task automatic idle();
      i_rden  = 1'b0;
      i_last  = 1'b0;
      rd_word = DW'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      sb_q.delete();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      idle();
      i_ready = 1'b1;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      tick();
      chk(tag, 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int n;
      int acc;
      int seen;
      int idx;

      // Reset state
      idle();
      tick();
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_last",  64'(o_last),  64'd0);
      chk("rst_stall", 64'(o_stall), 64'd0);
      chk("rst_err",   64'(o_err_ovf), 64'd0);
      chk("rst_data",  64'(o_data),  64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Single read: o_valid appears BRAM_LATENCY+1 cycles after the read, for one cycle
      i_ready = 1'b1;
      issue(32'hA5A5_0001, 1'b0);
      n = 0;
      tick();
      n++;
      idle();
      while (!o_valid && n < 20) begin
         tick();
         n++;
      end
      chk("lat_single", 64'(n), 64'(LAT + 1));
      chk("data_single", 64'(o_data), 64'hA5A5_0001);
      tick();
      chk("one_beat", 64'(o_valid), 64'd0);

      // Continuous reads honoring o_stall with consumer stalled
      i_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         chk("stall_fill", 64'(o_stall), 64'(acc >= DEF_FIFO_DEPTH));
         if (!o_stall) begin
            issue(32'h3400_0000 + 32'(acc), 1'b0);
            acc++;
         end else begin
            idle();
         end
         tick();
      end
      idle();
      chk("fill_accepted", 64'(acc), 64'(DEF_FIFO_DEPTH));
      chk("fill_cnt", 64'(dut.fifo_cnt), 64'(DEF_FIFO_DEPTH));
      chk("fill_head", 64'(o_data), 64'h3400_0000);
      drain("drain_fill");

      // 16 ordered reads, last flag on data 15, random consumer readiness
      idx = 0;
      n = 0;
      while (idx < 16 && n < 400) begin
         i_ready = 1'($urandom_range(0, 1));
         if (!o_stall) begin
            issue(DW'(idx), 1'(idx == 15));
            idx++;
         end else begin
            idle();
         end
         tick();
         n++;
      end
      chk("order_issued", 64'(idx), 64'd16);
      drain("drain_order");
      chk("order_err", 64'(o_err_ovf), 64'd0);

      // Full FIFO then sustained push/pop: occupancy never exceeds depth
      i_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         if (!o_stall && acc < DEF_FIFO_DEPTH) begin
            issue(32'h3600_0000 + 32'(acc), 1'b0);
            acc++;
         end else begin
            idle();
         end
         tick();
      end
      idle();
      chk("full_cnt", 64'(dut.fifo_cnt), 64'(DEF_FIFO_DEPTH));
      i_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (!o_stall) begin
            issue(32'h3610_0000 + 32'(c), 1'b0);
         end else begin
            idle();
         end
         tick();
         chk("full_bound", 64'((32'(dut.fifo_cnt) + 32'(dut.inflight_q)) > DEF_FIFO_DEPTH), 64'd0);
      end
      chk("full_err", 64'(o_err_ovf), 64'd0);
      drain("drain_full");

      // Read forced while stalled: sticky error, excess write dropped
      i_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         if (!o_stall && acc < DEF_FIFO_DEPTH) begin
            issue(32'h3700_0000 + 32'(acc), 1'b0);
            acc++;
         end else begin
            idle();
         end
         tick();
      end
      idle();
      chk("ovf_pre_err", 64'(o_err_ovf), 64'd0);
      chk("ovf_pre_stall", 64'(o_stall), 64'd1);
      i_rden  = 1'b1;
      rd_word = 32'hBAD0_0037;
      tick();
      idle();
      chk("ovf_set", 64'(o_err_ovf), 64'd1);
      for (int c = 0; c < 5; c++) tick();
      chk("ovf_hold", 64'(o_err_ovf), 64'd1);
      chk("ovf_no_overflow", 64'(dut.fifo_cnt), 64'(DEF_FIFO_DEPTH));
      chk("ovf_head_kept", 64'(o_data), 64'h3700_0000);
      do_reset();
      chk("ovf_cleared", 64'(o_err_ovf), 64'd0);
      chk("ovf_rst_valid", 64'(o_valid), 64'd0);

      // Reset with two reads in flight: nothing emerges afterwards
      i_ready = 1'b1;
      issue(32'h3800_0001, 1'b0);
      tick();
      issue(32'h3800_0002, 1'b1);
      tick();
      rst = 1'b1;
      idle();
      sb_q.delete();
      tick();
      chk("mid_rst_valid", 64'(o_valid), 64'd0);
      chk("mid_rst_stall", 64'(o_stall), 64'd0);
`ifdef DATA_RESP_DBG_EN
      chk("mid_rst_dbg_beat",  64'(dbg_beat),  64'd0);
      chk("mid_rst_dbg_stall", 64'(dbg_stall), 64'd0);
`endif
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (o_valid) seen++;
      end
      chk("no_stale_beats", 64'(seen), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_data_resp
